// File: rtl/wimax_pkg.sv
// Shared constants and types for the WiMAX FEC encoder.
// Tail-biting K=7 rate-1/2 convolutional code parameters.
package wimax_pkg;

    localparam int FEC_N_IN  = 96;
    localparam int FEC_N_OUT = 192;
    localparam int FEC_K     = 7;
    localparam int FEC_CW    = $clog2(FEC_N_IN);

    localparam logic [FEC_K-1:0] FEC_G1 = 7'o171;
    localparam logic [FEC_K-1:0] FEC_G2 = 7'o133;

    typedef enum logic [1:0] {
        FEC_IDLE,
        FEC_LOAD,
        FEC_STREAM
    } fec_state_t;

    function automatic logic fec_parity(
        input logic [FEC_K-1:0] g,
        input logic [FEC_K-1:0] v
    );
        return ^(g & v);
    endfunction

endpackage

// File: rtl/fec_encoder_cc_core.sv
// Convolutional core: 6-bit delay line plus X/Y parity trees.
// Generator MSB taps the current input, LSB taps the oldest delay.
module cc_core
    import wimax_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             preload,
    input  logic [FEC_K-2:0] sr_init,
    input  logic             shift,
    input  logic             u,
    output logic             x,
    output logic             y
);

    logic [FEC_K-2:0] r_sr;
    logic [FEC_K-1:0] w_vec;

    // r_sr[0] is delay 1, r_sr[5] is delay 6
    assign w_vec = {u, r_sr[0], r_sr[1], r_sr[2],
                    r_sr[3], r_sr[4], r_sr[5]};

    assign x = fec_parity(FEC_G1, w_vec);
    assign y = fec_parity(FEC_G2, w_vec);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sr <= '0;
        end else if (preload) begin
            r_sr <= sr_init;
        end else if (shift) begin
            r_sr <= {r_sr[FEC_K-3:0], u};
        end
    end

endmodule

// File: rtl/fec_encoder.sv
// Tail-biting rate-1/2 FEC encoder with ping-pong block buffer.
// Serial 96-bit blocks in, serial X/Y interleaved 192-bit blocks out.
module fec_encoder
    import wimax_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic input_data,
    input  logic data_valid,
    output logic ready_out,
    output logic output_data,
    output logic valid_out,
    input  logic ready_in
);

    logic [FEC_N_IN-1:0] r_bank [2];
    logic [1:0]          r_full;
    logic                r_wr_ptr;
    logic                r_rd_ptr;
    logic [FEC_CW-1:0]   r_wr_cnt;
    logic [FEC_CW-1:0]   r_rd_idx;
    logic                r_phase;
    logic                r_out_vld;
    fec_state_t          r_state;
    fec_state_t          w_next;

    logic             w_wr;
    logic             w_wr_last;
    logic             w_hs;
    logic             w_load;
    logic             w_shift;
    logic             w_done;
    logic             w_u;
    logic             w_x;
    logic             w_y;
    logic [FEC_K-2:0] w_pre;

    assign ready_out = ~r_full[r_wr_ptr];
    assign w_wr      = data_valid & ready_out;
    assign w_wr_last = w_wr &&
        (r_wr_cnt == FEC_CW'(FEC_N_IN - 1));
    assign w_hs      = r_out_vld & ready_in;
    assign w_u       = r_bank[r_rd_ptr][r_rd_idx];

    // Tail-biting preload: last block bit sits at delay 1
    always_comb begin
        w_pre = '0;
        for (int j = 0; j < FEC_K - 1; j++) begin
            w_pre[j] = r_bank[r_rd_ptr][FEC_N_IN-1-j];
        end
    end

    cc_core u_cc (
        .clk     (clk),
        .reset   (reset),
        .preload (w_load),
        .sr_init (w_pre),
        .shift   (w_shift),
        .u       (w_u),
        .x       (w_x),
        .y       (w_y)
    );

    assign valid_out   = r_out_vld;
    assign output_data = r_out_vld & (r_phase ? w_y : w_x);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= FEC_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_load  = 1'b0;
        w_shift = 1'b0;
        w_done  = 1'b0;
        unique case (r_state)
            FEC_IDLE: begin
                if (r_full[r_rd_ptr]) w_next = FEC_LOAD;
            end
            FEC_LOAD: begin
                w_load = 1'b1;
                w_next = FEC_STREAM;
            end
            FEC_STREAM: begin
                if (w_hs && r_phase) begin
                    w_shift = 1'b1;
                    if (r_rd_idx == FEC_CW'(FEC_N_IN - 1)) begin
                        w_done = 1'b1;
                        w_next = r_full[~r_rd_ptr] ? FEC_LOAD
                                                   : FEC_IDLE;
                    end
                end
            end
            default: w_next = FEC_IDLE;
        endcase
    end

    // Storage carries no reset; full flags gate all reads
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_bank[r_wr_ptr][r_wr_cnt] <= input_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_full    <= '0;
            r_wr_ptr  <= 1'b0;
            r_rd_ptr  <= 1'b0;
            r_wr_cnt  <= '0;
            r_rd_idx  <= '0;
            r_phase   <= 1'b0;
            r_out_vld <= 1'b0;
        end else begin
            if (w_wr) begin
                if (w_wr_last) begin
                    r_full[r_wr_ptr] <= 1'b1;
                    r_wr_ptr         <= ~r_wr_ptr;
                    r_wr_cnt         <= '0;
                end else begin
                    r_wr_cnt <= r_wr_cnt + 1'b1;
                end
            end
            if (w_load) begin
                r_rd_idx  <= '0;
                r_phase   <= 1'b0;
                r_out_vld <= 1'b1;
            end else if (w_hs) begin
                r_phase <= ~r_phase;
                if (w_done) begin
                    r_full[r_rd_ptr] <= 1'b0;
                    r_rd_ptr         <= ~r_rd_ptr;
                    r_rd_idx         <= '0;
                    r_out_vld        <= 1'b0;
                end else if (r_phase) begin
                    r_rd_idx <= r_rd_idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fec_encoder.sv
// Randomized self-checking bench for fec_encoder.
// Reference encoder works from the code definition with modular indexing.
module tb_fec_encoder;

    localparam int        N   = 96;
    localparam int        MAXC = 20000;
    localparam bit [6:0]  G1  = 7'o171;
    localparam bit [6:0]  G2  = 7'o133;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic input_data = 1'b0;
    logic data_valid = 1'b0;
    logic ready_out;
    logic output_data;
    logic valid_out;
    logic ready_in = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    bit         tx_q[$];
    bit         rx_q[$];
    bit [191:0] exp_q[$];
    bit         vo_hist[$];
    int         stall;
    int         last_acc;
    int         first_rise;

    always #5 clk = ~clk;

    fec_encoder dut (
        .clk         (clk),
        .reset       (reset),
        .input_data  (input_data),
        .data_valid  (data_valid),
        .ready_out   (ready_out),
        .output_data (output_data),
        .valid_out   (valid_out),
        .ready_in    (ready_in)
    );

    task automatic chk(input string tag,
                       input logic [191:0] got,
                       input logic [191:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Tap on delay k is generator bit 6-k; delay k reads d[(i-k) mod N]
    function automatic bit [191:0] ref_enc(input bit [N-1:0] d);
        bit [191:0] c;
        c = '0;
        for (int i = 0; i < N; i++) begin
            bit xv, yv;
            xv = 1'b0;
            yv = 1'b0;
            for (int k = 0; k < 7; k++) begin
                int idx;
                idx = (i - k + N) % N;
                xv ^= G1[6-k] & d[idx];
                yv ^= G2[6-k] & d[idx];
            end
            c[2*i]   = xv;
            c[2*i+1] = yv;
        end
        return c;
    endfunction

    task automatic send_block(input bit [N-1:0] d);
        for (int i = 0; i < N; i++) tx_q.push_back(d[i]);
        exp_q.push_back(ref_enc(d));
    endtask

    function automatic bit [N-1:0] rand_block();
        return {$urandom, $urandom, $urandom};
    endfunction

    task automatic run(input int target, input int thr_in,
                       input int thr_out, input int extra);
        int cyc;
        int tail;
        bit pv;
        cyc = 0;
        tail = 0;
        pv = 1'b0;
        vo_hist.delete();
        stall = 0;
        last_acc = -1;
        first_rise = -1;
        while (tail < extra) begin
            @(negedge clk);
            vo_hist.push_back(valid_out);
            if (valid_out && !pv && first_rise < 0 && last_acc >= 0)
                first_rise = cyc;
            pv = valid_out;
            ready_in = ($urandom_range(99) >= thr_out);
            if (valid_out && ready_in) rx_q.push_back(output_data);
            if (tx_q.size() > 0 && $urandom_range(99) >= thr_in) begin
                data_valid = 1'b1;
                input_data = tx_q[0];
            end else begin
                data_valid = 1'b0;
                input_data = 1'b0;
            end
            if (data_valid && !ready_out) stall++;
            if (data_valid && ready_out) begin
                tx_q.delete(0);
                if (tx_q.size() == 0) last_acc = cyc;
            end
            if (rx_q.size() >= target) tail++;
            cyc++;
            if (cyc > MAXC) begin
                chk("timeout", rx_q.size(), target);
                break;
            end
        end
        data_valid = 1'b0;
        input_data = 1'b0;
        ready_in = 1'b0;
    endtask

    task automatic check_blocks(input string tag);
        for (int b = 0; b < exp_q.size(); b++) begin
            bit [191:0] got;
            for (int j = 0; j < 192; j++) begin
                int p;
                p = b * 192 + j;
                got[j] = (p < rx_q.size()) ? rx_q[p] : 1'b0;
            end
            chk($sformatf("%s_blk%0d", tag, b), got, exp_q[b]);
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic gap_stats(output int ones, output int gaps,
                             output int bad);
        bit seen;
        int z;
        seen = 1'b0;
        z = 0;
        ones = 0;
        gaps = 0;
        bad = 0;
        foreach (vo_hist[i]) begin
            if (vo_hist[i]) begin
                ones++;
                if (seen && z > 0) begin
                    gaps++;
                    if (z != 1) bad++;
                end
                z = 0;
                seen = 1'b1;
            end else if (seen) begin
                z++;
            end
        end
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        data_valid = 1'b0;
        ready_in = 1'b0;
        tx_q.delete();
        rx_q.delete();
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int ones;
        int gaps;
        int bad;
        bit [N-1:0] d;
        bit [191:0] e;
        logic [0:13] p2;
        logic [0:11] p3;

        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_ready_out", ready_out, 1'b1);
        chk("rst_valid_out", valid_out, 1'b0);
        chk("rst_output_data", output_data, 1'b0);

        // All-zero block, full rate
        send_block('0);
        run(192, 0, 0, 6);
        gap_stats(ones, gaps, bad);
        chk("t1_ones", ones, 192);
        chk("t1_gaps", gaps, 0);
        chk("t1_latency", first_rise - last_acc, 3);
        check_blocks("t1");

        // Single impulse at bit 0
        d = '0;
        d[0] = 1'b1;
        send_block(d);
        p2 = 14'b11_10_11_11_00_01_11;
        e = '0;
        for (int j = 0; j < 14; j++) e[j] = p2[j];
        chk("t2_model_vs_table", exp_q[0], e);
        run(192, 0, 0, 4);
        check_blocks("t2");

        // Impulse at bit 95 exercises tail-biting wrap
        d = '0;
        d[N-1] = 1'b1;
        send_block(d);
        p3 = 12'b10_11_11_00_01_11;
        e = '0;
        for (int j = 0; j < 12; j++) e[j] = p3[j];
        e[190] = 1'b1;
        e[191] = 1'b1;
        chk("t3_model_vs_table", exp_q[0], e);
        run(192, 0, 0, 4);
        check_blocks("t3");

        // Random block, full rate
        send_block(rand_block());
        run(192, 0, 0, 4);
        check_blocks("t4");

        // Three back-to-back blocks, full rate
        for (int b = 0; b < 3; b++) send_block(rand_block());
        run(3 * 192, 0, 0, 4);
        gap_stats(ones, gaps, bad);
        chk("t5_stall_seen", (stall > 0), 1'b1);
        chk("t5_gaps", gaps, 2);
        chk("t5_gap_len", bad, 0);
        chk("t5_ones", ones, 3 * 192);
        check_blocks("t5");

        // Random throttling on both sides
        for (int b = 0; b < 4; b++) send_block(rand_block());
        run(4 * 192, 35, 40, 4);
        check_blocks("t5r");

        // Reset while loading bit 50
        for (int i = 0; i < 50; i++) tx_q.push_back(1'b1);
        run(0, 0, 0, 50);
        reset = 1'b0;
        #1;
        chk("t6a_valid_out", valid_out, 1'b0);
        chk("t6a_output_data", output_data, 1'b0);
        apply_reset();
        chk("t6a_ready_out", ready_out, 1'b1);
        send_block(rand_block());
        run(192, 0, 0, 4);
        check_blocks("t6a");

        // Reset at output bit 100
        send_block(rand_block());
        run(100, 0, 0, 1);
        reset = 1'b0;
        #1;
        chk("t6b_valid_out", valid_out, 1'b0);
        chk("t6b_output_data", output_data, 1'b0);
        apply_reset();
        run(0, 0, 0, 5);
        gap_stats(ones, gaps, bad);
        chk("t6b_no_residue", ones, 0);
        send_block(rand_block());
        run(192, 20, 20, 4);
        check_blocks("t6b");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
